// File: rtl/dcache_direct_mapped_pkg.sv
// rtl/dcache_direct_mapped_pkg.sv - shared constants and FSM encoding for the direct-mapped data cache
package dcache_direct_mapped_pkg;

   localparam int TAG_W  = 3;
   localparam int IDX_W  = 3;
   localparam int OFF_W  = 2;
   localparam int LINES  = 1 << IDX_W;
   localparam int BLK_W  = 32;
   localparam int MADR_W = TAG_W + IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WRITE_BACK = 2'd1,
      ST_MEM_READ   = 2'd2
   } state_t;

   function automatic logic [7:0] blk_byte(input logic [BLK_W-1:0] blk, input logic [OFF_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - data/tag/valid/dirty arrays with byte-write and block-fill ports
module dcache_line_store
   import dcache_direct_mapped_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [IDX_W-1:0]  i_idx,
   output logic [BLK_W-1:0]  o_data,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_valid,
   output logic              o_dirty,
   input  logic              i_wr_en,
   input  logic [OFF_W-1:0]  i_wr_off,
   input  logic [7:0]        i_wr_byte,
   input  logic              i_fill_en,
   input  logic [TAG_W-1:0]  i_fill_tag,
   input  logic [BLK_W-1:0]  i_fill_data
);

   logic [BLK_W-1:0] r_data [0:LINES-1];
   logic [TAG_W-1:0] r_tag  [0:LINES-1];
   logic [LINES-1:0] r_valid;
   logic [LINES-1:0] r_dirty;

   assign o_data  = r_data[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];

   // Data and tags carry no reset; only the valid/dirty state is cleared.
   always_ff @(posedge i_clk) begin
      if (i_fill_en) begin
         r_data[i_idx] <= i_fill_data;
         r_tag[i_idx]  <= i_fill_tag;
      end else if (i_wr_en) begin
         r_data[i_idx][{i_wr_off, 3'b000} +: 8] <= i_wr_byte;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_en) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_wr_en) begin
         r_dirty[i_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache, FSM and memory interface
module dcache_direct_mapped
   import dcache_direct_mapped_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               READ,
   input  logic               WRITE,
   input  logic [7:0]         ADDRESS,
   input  logic [7:0]         WRITEDATA,
   output logic [7:0]         READDATA,
   output logic               BUSYWAIT,
   output logic               MEM_READ,
   output logic               MEM_WRITE,
   output logic [MADR_W-1:0]  MEM_ADDRESS,
   output logic [BLK_W-1:0]   MEM_WRITEDATA,
   input  logic [BLK_W-1:0]   MEM_READDATA,
   input  logic               MEM_BUSYWAIT
);

   state_t r_state;
   state_t w_next;

   logic [MADR_W-1:0] r_mem_address;
   logic [BLK_W-1:0]  r_mem_writedata;
   logic [7:0]        r_readdata;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [OFF_W-1:0]  w_off;
   logic [BLK_W-1:0]  w_line;
   logic [TAG_W-1:0]  w_line_tag;
   logic              w_line_valid;
   logic              w_line_dirty;
   logic              w_hit;
   logic              w_idle;
   logic              w_rd_hit;
   logic              w_wr_hit;
   logic              w_fill_en;
   logic [7:0]        w_hit_byte;

   assign w_tag = ADDRESS[7:5];
   assign w_idx = ADDRESS[4:2];
   assign w_off = ADDRESS[1:0];

   dcache_line_store u_store (
      .i_clk       (CLK),
      .i_rst       (RESET),
      .i_idx       (w_idx),
      .o_data      (w_line),
      .o_tag       (w_line_tag),
      .o_valid     (w_line_valid),
      .o_dirty     (w_line_dirty),
      .i_wr_en     (w_wr_hit),
      .i_wr_off    (w_off),
      .i_wr_byte   (WRITEDATA),
      .i_fill_en   (w_fill_en),
      .i_fill_tag  (w_tag),
      .i_fill_data (MEM_READDATA)
   );

   assign w_hit      = w_line_valid && (w_line_tag == w_tag);
   assign w_idle     = (r_state == ST_IDLE);
   // WRITE wins when both request lines are high.
   assign w_wr_hit   = WRITE && w_idle && w_hit;
   assign w_rd_hit   = READ && !WRITE && w_idle && w_hit;
   assign w_hit_byte = blk_byte(w_line, w_off);

   assign BUSYWAIT = (READ || WRITE) && !(w_idle && w_hit);
   assign READDATA = w_rd_hit ? w_hit_byte : r_readdata;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_fill_en     = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = r_mem_address;
      MEM_WRITEDATA = r_mem_writedata;
      case (r_state)
         ST_IDLE: begin
            if ((READ || WRITE) && !w_hit) begin
               if (w_line_valid && w_line_dirty) w_next = ST_WRITE_BACK;
               else                              w_next = ST_MEM_READ;
            end
         end
         ST_WRITE_BACK: begin
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {w_line_tag, w_idx};
            MEM_WRITEDATA = w_line;
            if (!MEM_BUSYWAIT) w_next = ST_MEM_READ;
         end
         ST_MEM_READ: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[7:2];
            // The refill is installed even if the CPU dropped its request.
            if (!MEM_BUSYWAIT) begin
               w_fill_en = 1'b1;
               w_next    = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
         r_readdata      <= '0;
      end else begin
         r_mem_address   <= MEM_ADDRESS;
         r_mem_writedata <= MEM_WRITEDATA;
         if (w_rd_hit) r_readdata <= w_hit_byte;
      end
   end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 32-bit-block data memory.
- Its READDATA feeds the 8-bit writeback-select mux, which chooses between the ALU result and load data.
- Stalls the CPU via BUSYWAIT on a miss and runs the write-back and refill handshakes with data memory.

Parameters:
- None. Geometry is fixed: 8 lines × 4 bytes, 8-bit byte address.

Ports:
CLK  in  1  system clock; all state changes on posedge
RESET  in  1  asynchronous, active-high reset
READ  in  1  CPU load request
WRITE  in  1  CPU store request
ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0]
WRITEDATA  in  8  CPU store byte
READDATA  out  8  load byte to the writeback-select mux
BUSYWAIT  out  1  CPU stall
MEM_READ  out  1  memory block read strobe
MEM_WRITE  out  1  memory block write strobe
MEM_ADDRESS  out  6  memory block address {tag,index}
MEM_WRITEDATA  out  32  block being written back; byte0 = bits[7:0]
MEM_READDATA  in  32  refill block; byte0 = bits[7:0]
MEM_BUSYWAIT  in  1  memory busy; rises the same cycle a strobe rises, falls in the final cycle with data valid

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values:
  - all valid and dirty bits 0; FSM in IDLE
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0
  - READDATA=0, BUSYWAIT=0
  - data and tag arrays are not cleared.
- Request priority: if READ and WRITE are both high, treat it as WRITE (illegal from the CPU; the bench flags it).
- Hit: hit = valid[index] && tag[index]==ADDRESS[7:5]. Combinational from the current address.
- BUSYWAIT (combinational) = (READ|WRITE) && !(state==IDLE && hit).
- Read hit:
  - READDATA = data[index][offset], combinationally.
  - BUSYWAIT low, so zero stall cycles.
  - READDATA holds its last value when there is no read hit.
- Write hit: at posedge in IDLE, write WRITEDATA into data[index][offset] and set dirty[index]=1. No stall.
- FSM states and transitions:
  - IDLE: on a miss with valid&&dirty, go to WRITE_BACK. On a miss otherwise, go to MEM_READ.
  - WRITE_BACK:
    - drives MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index]
    - on a posedge with MEM_BUSYWAIT==0, go to MEM_READ.
  - MEM_READ:
    - drives MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]
    - on a posedge with MEM_BUSYWAIT==0: write MEM_READDATA into data[index], tag[index]=ADDRESS[7:5], valid=1, dirty=0, then go to IDLE.
  - Back in IDLE the access is now a hit and completes as above; the CPU sees BUSYWAIT fall.
- Strobes: outside WRITE_BACK and MEM_READ, MEM_READ=MEM_WRITE=0 and MEM_ADDRESS/MEM_WRITEDATA hold their last values.
- Miss latency, clean line: 1 (IDLE decision) + N_read + 1 (hit cycle).
- Miss latency, dirty line: adds N_write cycles.
- Request dropped mid-miss: the current memory transaction completes, the refill is still installed, then the FSM returns to IDLE. No abort.
- Address change mid-miss is illegal: the CPU holds ADDRESS while BUSYWAIT=1.
- Reset mid-operation:
  - the FSM returns to IDLE immediately and strobes drop asynchronously
  - all lines are invalidated and dirty data is discarded.
- Tag 0 / index 0 after reset: always misses, because valid=0.

Decomposition:
- Shared constants include: FSM state encodings (IDLE=2'd0, WRITE_BACK=2'd1, MEM_READ=2'd2) and address field widths (TAG_W=3, IDX_W=3, OFF_W=2).
- One sub-module, dcache_line_store:
  - holds the data/tag/valid/dirty arrays
  - combinational read port, synchronous byte-write port and block-fill port
  - asynchronous clear of valid/dirty.
- The top level holds the FSM, hit compare and the memory interface.

Test Plan:
- Reset, then READ addr 8'h05 with memory returning 32'hDDCCBBAA after 5 cycles:
  - MEM_READ=1 at MEM_ADDRESS 6'h01
  - BUSYWAIT falls after the refill
  - READDATA=8'hBB
  - a second READ 8'h05 hits with zero stall.
- WRITE 8'h5A to 8'h06 (line already resident): no stall, dirty set. Then READ 8'h06 gives READDATA=8'h5A.
- Dirty eviction, READ 8'h26 (same index 1, tag 1):
  - MEM_WRITE first, at MEM_ADDRESS 6'h01 with MEM_WRITEDATA=32'hDD5ABBAA
  - then MEM_READ at 6'h09.
- Clean eviction: replacing a clean line issues MEM_READ only and never MEM_WRITE.
- Reset asserted during MEM_READ:
  - MEM_READ and BUSYWAIT drop the same cycle
  - a following READ of the previously resident address misses.
- Write miss to 8'hE3 with no valid line:
  - refill from 6'h38, then byte 3 written
  - a READ of 8'hE3 returns the written byte and the line is dirty.
